// File: rtl/ntt_pkg.sv
// Shared constants, FSM states and twiddle helper
// for the Kyber NTT layer sequencer.
package ntt_pkg;

  localparam int N      = 256;
  localparam int Q      = 3329;
  localparam int LAYERS = 7;
  localparam int PAIRS  = N / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Twiddle index of block blk in a layer of size 2**lg.
  function automatic logic [6:0] calc_tw_idx(
    input logic [2:0] lg,
    input logic [6:0] blk,
    input logic       inverse
  );
    logic [8:0] t;
    if (inverse)
      t = (9'd256 >> lg) - 9'd1 - {2'b00, blk};
    else
      t = (9'd128 >> lg) + {2'b00, blk};
    return t[6:0];
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Shift register carrying {valid, a, b} from
// RAM read issue to butterfly write-back.
module ntt_addr_delay
  import ntt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          r,
  input  logic          in_valid,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          out_valid,
  output logic [AW-1:0] out_a,
  output logic [AW-1:0] out_b
);

  logic [DEPTH-1:0] v_q;
  logic [AW-1:0]    a_q [DEPTH];
  logic [AW-1:0]    b_q [DEPTH];

  // Shift one stage per cycle; reset empties the line.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      v_q[0] <= in_valid;
      a_q[0] <= in_a;
      b_q[0] <= in_b;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_layer_sequencer.sv
// Issues 7 NTT/INTT layers of coefficient pairs
// to the butterfly and writes results in place.
module ntt_layer_sequencer
  import ntt_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int BF_LAT  = 3,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          r,
  input  logic          start,
  input  logic          inverse,
  output logic          busy,
  output logic          done,
  output logic          seq_err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [11:0]   rd_data_a,
  input  logic [11:0]   rd_data_b,
  output logic [11:0]   bf_in1,
  output logic [11:0]   bf_in2,
  output logic          bf_valid_in,
  output logic          bf_inverse,
  output logic [6:0]    tw_idx,
  input  logic [11:0]   bf_u,
  input  logic [11:0]   bf_v,
  input  logic          bf_valid_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic [11:0]   wr_data_a,
  output logic [11:0]   wr_data_b
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]    state;
  logic [2:0]    layer;
  logic [6:0]    pair;
  logic          inv_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    inflight;
  logic [7:0]    inflight_nxt;
  logic          issue;
  logic [2:0]    lg;
  logic [3:0]    sh;
  logic [6:0]    blk;
  logic [6:0]    off;
  logic [AW-1:0] len;
  logic [AW-1:0] pa;
  logic [AW-1:0] pb;
  logic [6:0]    tw_now;
  logic          dl_valid;

  logic [RAM_LAT-1:0] v_pipe;
  logic [6:0]         tw_pipe [RAM_LAT];

  assign issue = (state == ST_ISSUE);
  assign lg    = inv_q ? (layer + 3'd1)
                       : (3'd7 - layer);
  assign sh    = {1'b0, lg} + 4'd1;
  assign blk   = pair >> lg;
  assign off   = pair & ((7'd1 << lg) - 7'd1);
  assign len   = AW'(1) << lg;
  assign pa    = (AW'(blk) << sh) + AW'(off);
  assign pb    = pa + len;
  assign tw_now = calc_tw_idx(lg, blk, inv_q);

  assign rd_en     = issue;
  assign rd_addr_a = issue ? pa : '0;
  assign rd_addr_b = issue ? pb : '0;

  assign inflight_nxt = inflight
                      + {7'b0, rd_en}
                      - {7'b0, dl_valid};

  // Layer/pair FSM; drain gates each layer change.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state  <= ST_IDLE;
      layer  <= '0;
      pair   <= '0;
      inv_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !done_q) begin
            state  <= ST_ISSUE;
            inv_q  <= inverse;
            busy_q <= 1'b1;
            layer  <= '0;
            pair   <= '0;
          end
        end
        ST_ISSUE: begin
          pair <= pair + 7'd1;
          if (pair == 7'(PAIRS - 1))
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (inflight_nxt == 8'd0) begin
            if (layer == 3'(LAYERS - 1)) begin
              state <= ST_DONE;
            end else begin
              layer <= layer + 3'd1;
              state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pairs issued but whose write slot has not passed.
  always_ff @(posedge clk or posedge r) begin
    if (r) inflight <= '0;
    else   inflight <= inflight_nxt;
  end

  // Align valid and twiddle with RAM read data.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      v_pipe <= '0;
      for (int i = 0; i < RAM_LAT; i++)
        tw_pipe[i] <= '0;
    end else begin
      v_pipe[0]  <= rd_en;
      tw_pipe[0] <= rd_en ? tw_now : 7'd0;
      for (int i = 1; i < RAM_LAT; i++) begin
        v_pipe[i]  <= v_pipe[i-1];
        tw_pipe[i] <= tw_pipe[i-1];
      end
    end
  end

  // Sticky flag for butterfly output off its slot.
  always_ff @(posedge clk or posedge r) begin
    if (r)
      err_q <= 1'b0;
    else if (bf_valid_out != dl_valid)
      err_q <= 1'b1;
  end

  ntt_addr_delay #(
    .DEPTH (RAM_LAT + BF_LAT),
    .AW    (AW)
  ) u_dly (
    .clk       (clk),
    .r         (r),
    .in_valid  (rd_en),
    .in_a      (rd_addr_a),
    .in_b      (rd_addr_b),
    .out_valid (dl_valid),
    .out_a     (wr_addr_a),
    .out_b     (wr_addr_b)
  );

  assign bf_valid_in = v_pipe[RAM_LAT-1];
  assign tw_idx      = tw_pipe[RAM_LAT-1];
  assign bf_inverse  = inv_q;
  assign bf_in1      = bf_valid_in ? rd_data_a : '0;
  assign bf_in2      = bf_valid_in ? rd_data_b : '0;

  assign wr_en     = bf_valid_out & busy_q & ~r;
  assign wr_data_a = wr_en ? bf_u : '0;
  assign wr_data_b = wr_en ? bf_v : '0;

  assign busy    = busy_q;
  assign done    = done_q;
  assign seq_err = err_q;

endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// Bench: RAM + ideal Kyber butterfly around the
// sequencer, checked against a reference NTT loop.
module tb_ntt_layer_sequencer;

  localparam int AW = 8;
  localparam int Q  = 3329;

  logic        clk;
  logic        r;
  logic        start;
  logic        inverse;
  logic        busy;
  logic        done;
  logic        seq_err;
  logic        rd_en;
  logic [7:0]  rd_addr_a;
  logic [7:0]  rd_addr_b;
  logic [11:0] rd_data_a;
  logic [11:0] rd_data_b;
  logic [11:0] bf_in1;
  logic [11:0] bf_in2;
  logic        bf_valid_in;
  logic        bf_inverse;
  logic [6:0]  tw_idx;
  logic [11:0] bf_u;
  logic [11:0] bf_v;
  logic        bf_valid_out;
  logic        wr_en;
  logic [7:0]  wr_addr_a;
  logic [7:0]  wr_addr_b;
  logic [11:0] wr_data_a;
  logic [11:0] wr_data_b;

  ntt_layer_sequencer #(
    .RAM_LAT (1),
    .BF_LAT  (3),
    .AW      (AW)
  ) dut (
    .clk          (clk),
    .r            (r),
    .start        (start),
    .inverse      (inverse),
    .busy         (busy),
    .done         (done),
    .seq_err      (seq_err),
    .rd_en        (rd_en),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .bf_in1       (bf_in1),
    .bf_in2       (bf_in2),
    .bf_valid_in  (bf_valid_in),
    .bf_inverse   (bf_inverse),
    .tw_idx       (tw_idx),
    .bf_u         (bf_u),
    .bf_v         (bf_v),
    .bf_valid_out (bf_valid_out),
    .wr_en        (wr_en),
    .wr_addr_a    (wr_addr_a),
    .wr_addr_b    (wr_addr_b),
    .wr_data_a    (wr_data_a),
    .wr_data_b    (wr_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // zeta[tw] = 17^bitrev7(tw) mod q
  function automatic int zeta(input int tw);
    int br;
    int z;
    br = 0;
    for (int i = 0; i < 7; i++)
      if (((tw >> i) & 1) == 1)
        br = br | (1 << (6 - i));
    z = 1;
    for (int k = 0; k < br; k++)
      z = (z * 17) % Q;
    return z;
  endfunction

  function automatic void bfly(
    input int a, input int b, input int tw,
    input bit inv, output int u, output int v);
    int z;
    int t;
    z = zeta(tw);
    if (!inv) begin
      t = (z * b) % Q;
      u = (a + t) % Q;
      v = (a - t + Q) % Q;
    end else begin
      u = (a + b) % Q;
      v = (z * ((b - a + Q) % Q)) % Q;
    end
  endfunction

  // Coefficient RAM with a bench load port.
  logic [11:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [11:0] ld_data;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
    if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
    if (ld_en)
      mem[ld_addr] <= ld_data;
  end

  // Ideal 3-cycle butterfly with drop/inject hooks.
  int   bu;
  int   bv;
  int   bf_cnt;
  int   drop_idx;
  logic inj;
  logic        s1v, s2v, s3v;
  logic [11:0] s1u, s2u, s3u;
  logic [11:0] s1w, s2w, s3w;

  always_comb begin
    bu = 0;
    bv = 0;
    bfly(int'(bf_in1), int'(bf_in2),
         int'(tw_idx), bf_inverse, bu, bv);
  end

  always @(posedge clk) begin
    if (!busy)
      bf_cnt <= 0;
    else if (bf_valid_in)
      bf_cnt <= bf_cnt + 1;
    s1v <= bf_valid_in && (bf_cnt != drop_idx);
    s1u <= bu[11:0];
    s1w <= bv[11:0];
    s2v <= s1v; s2u <= s1u; s2w <= s1w;
    s3v <= s2v; s3u <= s2u; s3w <= s2w;
  end

  assign bf_valid_out = s3v | inj;
  assign bf_u = s3u;
  assign bf_v = s3w;

  // Reference model: Kyber loop over start/j.
  int refmem [256];
  int ea[$];
  int eb[$];
  int et[$];
  int qa[$];
  int qb[$];
  int qt[$];

  task automatic build_ref(input bit inv,
                           input bit apply);
    int k, len, z, u, v;
    ea.delete(); eb.delete(); et.delete();
    k = inv ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      len = inv ? (2 << l) : (128 >> l);
      for (int s = 0; s < 256; s += 2 * len) begin
        z = k;
        k = inv ? k - 1 : k + 1;
        for (int j = s; j < s + len; j++) begin
          ea.push_back(j);
          eb.push_back(j + len);
          et.push_back(z);
          if (apply) begin
            bfly(refmem[j], refmem[j+len], z,
                 inv, u, v);
            refmem[j]     = u;
            refmem[j+len] = v;
          end
        end
      end
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(i);
      ld_data = 12'($urandom_range(0, Q - 1));
      refmem[i] = int'(ld_data);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run(input bit inv,
                     input int bs_at,
                     input int abort_at,
                     input bit start_on_done,
                     output int cyc,
                     output int wrc);
    qa.delete(); qb.delete(); qt.delete();
    wrc = 0;
    cyc = 0;
    @(negedge clk);
    start   = 1'b1;
    inverse = inv;
    @(negedge clk);
    start = 1'b0;
    while (1) begin
      if (rd_en) begin
        qa.push_back(int'(rd_addr_a));
        qb.push_back(int'(rd_addr_b));
      end
      if (bf_valid_in)
        qt.push_back(int'(tw_idx));
      if (wr_en)
        wrc++;
      if (done || cyc == abort_at || cyc >= 1500)
        break;
      @(negedge clk);
      cyc++;
      start   = (cyc == bs_at);
      inverse = (cyc == bs_at) ? ~inv : inv;
    end
    start   = 1'b0;
    inverse = inv;
    if (done && start_on_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic chk_sched(input string nm);
    int bad;
    int badt;
    bad  = 0;
    badt = 0;
    chk({nm, "_len"}, qa.size(), ea.size());
    chk({nm, "_twlen"}, qt.size(), et.size());
    for (int i = 0; i < ea.size(); i++) begin
      if (i >= qa.size() || qa[i] != ea[i]
          || qb[i] != eb[i])
        bad++;
      if (i >= qt.size() || qt[i] != et[i])
        badt++;
    end
    chk({nm, "_addr"}, bad, 0);
    chk({nm, "_tw"}, badt, 0);
  endtask

  task automatic chk_ram(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (int'(mem[i]) != refmem[i])
        bad++;
    chk(nm, bad, 0);
  endtask

  typedef struct {
    bit inv;
    int idx;
    int a;
    int b;
    int tw;
  } vec_t;

  vec_t vt [9];

  task automatic chk_table(input bit inv);
    int ga, gb, gt;
    for (int i = 0; i < 9; i++) begin
      if (vt[i].inv == inv) begin
        ga = (vt[i].idx < qa.size())
             ? qa[vt[i].idx] : -1;
        gb = (vt[i].idx < qb.size())
             ? qb[vt[i].idx] : -1;
        gt = (vt[i].idx < qt.size())
             ? qt[vt[i].idx] : -1;
        chk($sformatf("vec%0d_a", i), ga, vt[i].a);
        chk($sformatf("vec%0d_b", i), gb, vt[i].b);
        chk($sformatf("vec%0d_tw", i), gt, vt[i].tw);
      end
    end
  endtask

  function automatic int outs_nz();
    return int'(|{busy, done, seq_err, rd_en,
                  rd_addr_a, rd_addr_b, bf_in1,
                  bf_in2, bf_valid_in, bf_inverse,
                  tw_idx, wr_en, wr_addr_a,
                  wr_addr_b, wr_data_a, wr_data_b});
  endfunction

  int cyc;
  int wrc;
  int wr_r;

  initial begin
    vt[0] = '{0, 0,   0,   128, 1};
    vt[1] = '{0, 128, 0,   64,  2};
    vt[2] = '{0, 192, 128, 192, 3};
    vt[3] = '{0, 768, 0,   2,   64};
    vt[4] = '{0, 769, 1,   3,   64};
    vt[5] = '{0, 770, 4,   6,   65};
    vt[6] = '{0, 895, 253, 255, 127};
    vt[7] = '{1, 0,   0,   2,   127};
    vt[8] = '{1, 768, 0,   128, 1};

    r        = 1'b1;
    start    = 1'b0;
    inverse  = 1'b0;
    inj      = 1'b0;
    drop_idx = -1;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", outs_nz(), 0);
    r = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", outs_nz(), 0);

    // NTT full run
    fill();
    build_ref(1'b0, 1'b1);
    run(1'b0, -1, -1, 1'b0, cyc, wrc);
    chk("ntt_done_cyc", cyc, 925);
    chk("ntt_busy_fall", int'(busy), 0);
    chk("ntt_writes", wrc, 896);
    chk_sched("ntt");
    chk_table(1'b0);
    chk_ram("ntt_ram");
    chk("ntt_err", int'(seq_err), 0);

    // INTT on NTT output; start at done ignored
    build_ref(1'b1, 1'b1);
    run(1'b1, -1, -1, 1'b1, cyc, wrc);
    chk("intt_done_cyc", cyc, 925);
    chk("intt_writes", wrc, 896);
    chk_sched("intt");
    chk_table(1'b1);
    chk_ram("intt_ram");
    chk("intt_inv", int'(bf_inverse), 1);
    repeat (2) @(negedge clk);
    chk("start_on_done", int'(busy), 0);

    // Reset mid-run
    fill();
    run(1'b0, -1, 300, 1'b0, cyc, wrc);
    chk("abort_busy", int'(busy), 1);
    r = 1'b1;
    wr_r = 0;
    @(negedge clk);
    chk("abort_outs", outs_nz(), 0);
    repeat (5) begin
      @(negedge clk);
      if (wr_en) wr_r++;
    end
    r = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en) wr_r++;
    end
    chk("abort_no_wr", wr_r, 0);
    chk("abort_err", int'(seq_err), 0);

    // Stray valid while idle
    inj = 1'b1;
    chk("idle_no_wr", int'(wr_en), 0);
    @(negedge clk);
    inj = 1'b0;
    chk("idle_err", int'(seq_err), 1);
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    chk("err_clear", int'(seq_err), 0);

    // Fresh run after abort
    fill();
    build_ref(1'b0, 1'b1);
    run(1'b0, -1, -1, 1'b0, cyc, wrc);
    chk("fresh_done_cyc", cyc, 925);
    chk("fresh_writes", wrc, 896);
    chk_ram("fresh_ram");

    // Dropped valid at pair 10, start while busy
    drop_idx = 10;
    build_ref(1'b0, 1'b0);
    run(1'b0, 50, -1, 1'b0, cyc, wrc);
    chk("drop_done_cyc", cyc, 925);
    chk("drop_writes", wrc, 895);
    chk_sched("drop");
    chk("drop_inv", int'(bf_inverse), 0);
    chk("drop_err", int'(seq_err), 1);
    drop_idx = -1;
    repeat (5) @(negedge clk);
    chk("drop_err_sticky", int'(seq_err), 1);
    chk("drop_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
